// File: rtl/pool_pkg.sv
// Shared types and arithmetic helpers for the streaming max-pool family.
// Helpers work on a 64-bit signed type, so element widths up to 64 bits are supported.
package pool_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int CALC_W     = 64;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  typedef logic signed [CALC_W-1:0] calc_t;

  function automatic calc_t smax(input calc_t a, input calc_t b);
    return (a > b) ? a : b;
  endfunction

  function automatic calc_t relu(input calc_t x);
    return (x < 0) ? '0 : x;
  endfunction

endpackage

// File: rtl/max_pool_cmp.sv
// Combinational signed two-input maximum with optional ReLU clamp on a second output.
// max_o is always the raw maximum; y_o is clamped at zero when relu_en is set.
module max_pool_cmp
  import pool_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic signed [DATA_W-1:0] a_i,
  input  logic signed [DATA_W-1:0] b_i,
  input  logic                     relu_en,
  output logic signed [DATA_W-1:0] max_o,
  output logic signed [DATA_W-1:0] y_o
);

  calc_t max_w;

  // Operands are sign-extended before comparing, so the most-negative value orders correctly.
  always_comb begin
    max_w = smax(calc_t'(a_i), calc_t'(b_i));
    max_o = DATA_W'(max_w);
    y_o   = DATA_W'(relu_en ? relu(max_w) : max_w);
  end

endmodule

// File: rtl/max_pool_stream.sv
// Streaming signed max-pool: reduces WIN*WIN handshaked elements to one registered maximum,
// optionally ReLU-clamped, with a zero-bubble handoff between consecutive windows.
module max_pool_stream
  import pool_pkg::*;
#(
  parameter  int DATA_W = DATA_W_DEF,
  parameter  int WIN    = 3,
  localparam int N      = WIN * WIN,
  localparam int CNT_W  = (N > 1) ? $clog2(N) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     win_clr,
  input  logic                     relu_en,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CNT_W-1:0]         elem_cnt
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N - 1);

  state_e                   state_q, state_d;
  logic signed [DATA_W-1:0] acc_q, acc_d;
  logic signed [DATA_W-1:0] out_data_q, out_data_d;
  logic                     out_valid_q, out_valid_d;
  logic                     relu_q, relu_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;

  logic                     accept, first, last, relu_eff;
  logic signed [DATA_W-1:0] max_raw, pooled;

  // win_clr blocks acceptance so an aborted cycle can never start a new window.
  assign in_ready = !win_clr && ((state_q == ACCUM) || (state_q == HOLD && out_ready));
  assign accept   = in_valid && in_ready;
  assign first    = (cnt_q == '0);
  assign last     = (cnt_q == LAST_IDX);
  // The first element carries the mode for its own window, which matters when WIN=1.
  assign relu_eff = first ? relu_en : relu_q;

  max_pool_cmp #(.DATA_W(DATA_W)) u_cmp (
    .a_i     (in_data),
    .b_i     (first ? in_data : acc_q),
    .relu_en (relu_eff),
    .max_o   (max_raw),
    .y_o     (pooled)
  );

  // NOTE: every variable gets a hold default first, so no path through this block infers a latch.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    relu_d      = relu_q;
    cnt_d       = cnt_q;

    if (win_clr) begin
      state_d     = ACCUM;
      cnt_d       = '0;
      out_valid_d = 1'b0;
    end else begin
      if (state_q == HOLD && out_ready) begin
        state_d     = ACCUM;
        out_valid_d = 1'b0;
      end
      if (accept) begin
        acc_d = max_raw;
        if (first) begin
          relu_d = relu_en;
        end
        if (last) begin
          state_d     = HOLD;
          out_valid_d = 1'b1;
          out_data_d  = pooled;
          cnt_d       = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end
  end

  // NOTE: state flops use non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      relu_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      relu_q      <= relu_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign elem_cnt  = cnt_q;

endmodule

// File: tb/tb_max_pool_stream.sv
// Self-checking bench for max_pool_stream (WIN=3): directed scenarios plus randomized traffic
// scored against a window-list reference model.
module tb_max_pool_stream;

  localparam int N = 9;

  logic        clk;
  logic        rst;
  logic        win_clr;
  logic        relu_en;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  elem_cnt;

  int errors = 0;
  int checks = 0;
  int n_out  = 0;

  int   win_q[$];
  int   exp_q[$];
  logic win_relu = 1'b0;
  int   win_v[N];

  max_pool_stream #(.DATA_W(32), .WIN(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .win_clr   (win_clr),
    .relu_en   (relu_en),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .elem_cnt  (elem_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: collects accepted elements into a list, and once N are present
  // queues max(list), clamped at zero if the first element requested ReLU.
  always @(negedge clk) begin
    int m;
    #1;
    if (!rst) begin
      check("in_ready", in_ready, !win_clr && (exp_q.size() == 0 || out_ready));
      check("out_valid", out_valid, exp_q.size() != 0);
      if (win_clr) begin
        win_q.delete();
        exp_q.delete();
      end else begin
        if (out_valid && out_ready && exp_q.size() != 0) begin
          check("pool_out", out_data, exp_q.pop_front());
          n_out++;
        end
        if (in_valid && in_ready) begin
          if (win_q.size() == 0) win_relu = relu_en;
          win_q.push_back(int'(in_data));
          if (win_q.size() == N) begin
            m = win_q[0];
            foreach (win_q[i]) if (win_q[i] > m) m = win_q[i];
            if (win_relu && m < 0) m = 0;
            exp_q.push_back(m);
            win_q.delete();
          end
        end
      end
    end
  end

  // One clock cycle: inputs change on the falling edge, outputs are observed 2 ns later.
  task automatic cycle(input logic v, input logic [31:0] d, input logic r,
                       input logic ordy, input logic clr);
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    relu_en   = r;
    out_ready = ordy;
    win_clr   = clr;
    #2;
  endtask

  task automatic run_window(input logic r_first, input logic r_rest, input logic ordy);
    for (int i = 0; i < N; i++) cycle(1'b1, win_v[i], (i == 0) ? r_first : r_rest, ordy, 1'b0);
    cycle(1'b0, 32'd0, 1'b0, ordy, 1'b0);
  endtask

  task automatic async_reset(input string tag, input logic chk_cnt);
    @(posedge clk);
    #3;
    in_valid = 1'b0;
    rst      = 1'b1;
    win_q.delete();
    exp_q.delete();
    #1;
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_data"}, out_data, 0);
    if (chk_cnt) check({tag, "_elem_cnt"}, elem_cnt, 0);
    @(negedge clk);
    #4;
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; win_clr = 1'b0; relu_en = 1'b0;
    in_data = '0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_elem_cnt", elem_cnt, 0);
    check("rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;

    // Mixed-sign window, back-to-back, with latency checks
    win_v = '{5, -3, 12, 7, 0, -8, 12, 1, 2};
    for (int i = 0; i < N; i++) begin
      cycle(1'b1, win_v[i], 1'b0, 1'b1, 1'b0);
      if (i == 4) check("t1_cnt_mid", elem_cnt, 4);
      if (i == 8) begin
        check("t1_cnt_before_last", elem_cnt, 8);
        check("t1_no_early_valid", out_valid, 0);
      end
    end
    cycle(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
    check("t1_valid", out_valid, 1);
    check("t1_data", out_data, 12);
    check("t1_cnt_wrap", elem_cnt, 0);
    cycle(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
    check("t1_valid_drop", out_valid, 0);

    // All-negative window, with and without ReLU
    win_v = '{-5, -9, -3, -7, -1, -2, -8, -4, -6};
    run_window(1'b0, 1'b0, 1'b1);
    check("t2_neg_max", out_data, 32'hFFFF_FFFF);
    run_window(1'b1, 1'b1, 1'b1);
    check("t2_neg_relu", out_data, 0);

    // Back-pressure then zero-bubble handoff
    win_v = '{1, 42, 3, 4, 5, 6, 7, 8, 9};
    run_window(1'b0, 1'b0, 1'b0);
    check("t3_hold_valid", out_valid, 1);
    check("t3_hold_data", out_data, 42);
    for (int k = 0; k < 4; k++) begin
      cycle(1'b1, 32'd100, 1'b0, 1'b0, 1'b0);
      check("t3_bp_in_ready", in_ready, 0);
      check("t3_bp_data", out_data, 42);
      check("t3_bp_cnt", elem_cnt, 0);
    end
    cycle(1'b1, 32'd100, 1'b0, 1'b1, 1'b0);
    check("t3_handoff_ready", in_ready, 1);
    for (int i = 1; i < N; i++) begin
      cycle(1'b1, 32'd100, 1'b0, 1'b1, 1'b0);
      if (i == 1) begin
        check("t3_first_taken", elem_cnt, 1);
        check("t3_valid_cleared", out_valid, 0);
      end
    end
    cycle(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
    check("t3_next_data", out_data, 100);

    // ReLU mode latched from the first element only
    win_v = '{-5, -5, -5, -5, -5, -5, -5, -5, -5};
    run_window(1'b0, 1'b1, 1'b1);
    check("t4_mode_latch", out_data, 32'hFFFF_FFFB);

    // Abort mid-window, then a clean window
    cycle(1'b1, 32'd50, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 32'd60, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 32'd70, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 32'd80, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 32'd99, 1'b0, 1'b1, 1'b1);
    check("t5_clr_blocks", in_ready, 0);
    cycle(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
    check("t5_clr_cnt", elem_cnt, 0);
    win_v = '{3, 3, 3, 3, 3, 3, 3, 3, 3};
    run_window(1'b0, 1'b0, 1'b1);
    check("t5_after_clr", out_data, 3);

    // Abort while holding a result
    win_v = '{7, 7, 7, 7, 7, 7, 7, 7, 7};
    run_window(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
    check("t5_clr_hold", out_valid, 0);

    // Asynchronous reset in HOLD and mid-window
    win_v = '{11, 12, 13, 14, 15, 16, 17, 18, 19};
    run_window(1'b0, 1'b0, 1'b0);
    async_reset("t6_hold", 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 32'd200 + i, 1'b0, 1'b1, 1'b0);
    check("t6_cnt_before_rst", elem_cnt, 3);
    async_reset("t6_mid", 1'b1);
    cycle(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
    check("t6_ready_after_rst", in_ready, 1);
    win_v = '{32'sh8000_0000, 32'sh7FFF_FFFF, 0, -1, 1, 32'sh8000_0000, 5, -5, 0};
    run_window(1'b0, 1'b0, 1'b1);
    check("t6_extreme_max", out_data, 32'h7FFF_FFFF);
    win_v = '{32'sh8000_0000, 32'sh8000_0000, 32'sh8000_0000, 32'sh8000_0000, 32'sh8000_0000,
              32'sh8000_0000, 32'sh8000_0000, 32'sh8000_0000, 32'sh8000_0000};
    run_window(1'b0, 1'b0, 1'b1);
    check("t6_all_min", out_data, 32'h8000_0000);

    // Randomized traffic against the reference model
    for (int c = 0; c < 3000; c++) begin
      int          sel;
      logic [31:0] d;
      sel = $urandom_range(0, 9);
      if (sel == 0)      d = 32'h8000_0000;
      else if (sel == 1) d = 32'h7FFF_FFFF;
      else if (sel < 6)  d = 32'(int'($urandom_range(0, 40)) - 20);
      else               d = $urandom;
      cycle($urandom_range(0, 3) != 0, d, $urandom_range(0, 1) != 0,
            $urandom_range(0, 3) != 0, $urandom_range(0, 99) == 0);
    end
    repeat (3) cycle(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
    check("drain_empty", exp_q.size(), 0);
    check("results_seen", n_out > 100, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/max_pool_stream.md
Name: max_pool_stream

Overview:
- Streaming signed max-pool reducer; successor to the fixed 3x3 nine-input pooler.
- Accepts one window element per handshake and reduces WIN*WIN elements to a single maximum.
- Optionally clamps the result at zero (ReLU).
- Sits between the convolution result stream and the pooled-feature writeback; valid/ready on both sides.

Parameters:
- DATA_W, 32: element width; two's-complement signed.
- WIN, 3: window side length; window holds N = WIN*WIN elements; legal range 1..16.
- CNT_W, $clog2(WIN*WIN) (minimum 1): element counter width; derived, not overridden.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- win_clr  in  1  synchronous abort; discards the partial window and any pending result.
- relu_en  in  1  mode select; sampled with the first element of each window.
- in_data  in  DATA_W  window element, signed.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block can accept an element this cycle.
- out_data  out  DATA_W  pooled result, signed.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts out_data.
- elem_cnt  out  CNT_W  number of elements accepted in the current window (debug).

Behaviour:
- Reset (async, rst=1): out_valid=0, out_data=0, elem_cnt=0, accumulator=0, latched relu=0, state=ACCUM. in_ready is 1 after reset.
- Accept rule: an element is accepted when in_valid && in_ready.
- in_ready = (state==ACCUM) || (state==HOLD && out_ready). This allows a zero-bubble handoff to the next window.
- States:
  - ACCUM: collecting elements.
  - HOLD: result valid, waiting for out_ready.
- First element (elem_cnt==0) accepted: acc <= in_data; relu_lat <= relu_en.
- Later elements: acc <= (in_data > acc, signed) ? in_data : acc.
- When the accepted element is number N (elem_cnt==N-1):
  - Next cycle: state=HOLD, out_valid=1.
  - out_data = relu_lat ? max(final,0) : final.
  - elem_cnt wraps to 0.
- Latency: last element accepted at edge t -> out_valid high after edge t. Result is registered.
- Throughput: one element per cycle, sustained, with no bubble between windows while out_ready=1.
- HOLD with out_ready=0: out_data and out_valid stay stable, in_ready=0, acc is frozen.
- HOLD with out_ready=1:
  - With no input: return to ACCUM, out_valid=0.
  - With an input accepted the same cycle: that element is the first of the new window.
- WIN=1: every accepted element goes straight to HOLD with its (optionally ReLU'd) value.
- Equal values: the comparison is strict; the result is the same either way.
- Extreme values: most-negative values are handled correctly, so an all-negative window with relu_lat=0 returns the true negative maximum.
- ReLU mode: relu_en changes mid-window are ignored; only the value sampled on the first element applies.
- win_clr=1 (sync) has priority over every other event that cycle:
  - state=ACCUM, elem_cnt=0, out_valid=0.
  - No element is accepted that cycle: in_ready is forced to 0 while win_clr=1.
- Reset mid-window or in HOLD: all state is lost immediately; no result is emitted.

Decomposition:
- Shared package pool_pkg holds:
  - state enum {ACCUM, HOLD};
  - DATA_W default constant;
  - function smax(a,b) doing signed maximum;
  - function relu(x).
- One sub-module is natural: max_pool_cmp, a combinational signed two-input max with a relu_en pin. It replaces the separate max/max-relu cells and is reusable by later pooling variants.
- FSM, counter and handshake stay in the top module.

Test Plan:
- WIN=3, relu_en=0, elements 5,-3,12,7,0,-8,12,1,2 streamed back-to-back, out_ready=1 -> out_data=12, out_valid 1 cycle after the 9th accept, elem_cnt returns to 0.
- WIN=3, all nine elements negative (-9..-1, e.g. -1 at position 4): relu_en=0 -> out_data=-1; same window with relu_en=1 on the first element -> out_data=0.
- Back-pressure: hold out_ready=0 for 4 cycles after a window completes -> out_data stable, in_ready=0, no input consumed. Then raise out_ready with the next window's first element valid -> that element is accepted the same cycle, and the next result is correct (window 100×9 -> 100).
- Mode latch: relu_en=0 on element 1, then 1 on elements 2..9, with window values all -5 -> out_data=-5.
- win_clr after 4 of 9 elements (values 50,60,70,80), then 9 fresh elements of value 3 -> single output 3, with no trace of 80.
- Async rst asserted mid-window between clock edges -> out_valid, out_data and elem_cnt go to 0 immediately. A fresh window afterwards pools correctly, including the boundary pair 0x8000_0000 and 0x7FFF_FFFF -> out_data=0x7FFF_FFFF.
